// File: rtl/drive_mode_scheduler_if.sv
// Bundle between the three driving-mode blocks, the power button and the chassis/LED stage.
// The master side drives mode requests and commands; the scheduler sits on the slave side.
interface drive_mode_scheduler_if;
    logic       power_btn;
    logic [1:0] mode_req;
    logic [3:0] cmd_manual;
    logic [3:0] cmd_semi;
    logic [3:0] cmd_auto;
    logic [2:0] stopped_vec;
    logic       power_now;
    logic [2:0] grant;
    logic [3:0] motor_cmd;
    logic [1:0] sched_state;
    logic       switch_busy;

    modport master (
        output power_btn, mode_req, cmd_manual, cmd_semi, cmd_auto, stopped_vec,
        input  power_now, grant, motor_cmd, sched_state, switch_busy
    );

    modport slave (
        input  power_btn, mode_req, cmd_manual, cmd_semi, cmd_auto, stopped_vec,
        output power_now, grant, motor_cmd, sched_state, switch_busy
    );
endinterface

// File: rtl/drive_mode_scheduler.sv
// Car power sequencing and single-owner arbitration of the motor/turn actuator
// between the manual, semi-auto and auto mode blocks, with drain-to-stop on mode change.
module drive_mode_scheduler #(
    parameter int unsigned PWR_OFF_CYC = 300_000_000,
    parameter int unsigned DRAIN_CYC   = 10_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    drive_mode_scheduler_if.slave   bus
);

    localparam int unsigned HW = $clog2(PWR_OFF_CYC + 1);
    localparam int unsigned DW = $clog2(DRAIN_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(PWR_OFF_CYC - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        S_OFF      = 2'b00,
        S_RUN      = 2'b01,
        S_DRAIN    = 2'b10,
        S_HANDOVER = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        M_MANUAL = 2'b00,
        M_SEMI   = 2'b01,
        M_AUTO   = 2'b10
    } mode_e;

    state_e        state;
    state_e        state_nxt;
    mode_e         owner;
    mode_e         target;
    logic [DW-1:0] drain_cnt;
    logic [HW-1:0] hold_cnt;
    logic          armed;
    logic          prev_btn;
    logic [3:0]    motor_q;

    logic          btn_rise;
    logic          pwr_off;
    logic          req_switch;
    logic          owner_stopped;
    logic [3:0]    owner_cmd;
    logic [2:0]    grant_c;

    function automatic logic [3:0] sanitise(input logic [3:0] c);
        logic [3:0] r;
        r = c;
        if (c[3] && c[2]) r[3:2] = '0;
        if (c[1] && c[0]) r[1:0] = '0;
        return r;
    endfunction

    assign btn_rise   = bus.power_btn && !prev_btn;
    assign req_switch = (bus.mode_req != 2'b11) && (bus.mode_req != owner);
    // Only presses made after the button was released once while powered count toward power-off.
    assign pwr_off    = (state != S_OFF) && armed && bus.power_btn && (hold_cnt == HOLD_LAST);

    always_comb begin
        owner_cmd     = '0;
        owner_stopped = 1'b0;
        grant_c       = '0;
        case (owner)
            M_MANUAL: begin
                owner_cmd     = bus.cmd_manual;
                owner_stopped = bus.stopped_vec[0];
                grant_c       = 3'b001;
            end
            M_SEMI: begin
                owner_cmd     = bus.cmd_semi;
                owner_stopped = bus.stopped_vec[1];
                grant_c       = 3'b010;
            end
            M_AUTO: begin
                owner_cmd     = bus.cmd_auto;
                owner_stopped = bus.stopped_vec[2];
                grant_c       = 3'b100;
            end
            default: ;
        endcase
        if (state != S_RUN && state != S_DRAIN) grant_c = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:      if (btn_rise) state_nxt = S_RUN;
            S_RUN:      if (req_switch) state_nxt = S_DRAIN;
            S_DRAIN:    if (drain_cnt >= DRAIN_LAST && owner_stopped) state_nxt = S_HANDOVER;
            S_HANDOVER: state_nxt = S_RUN;
            default:    state_nxt = S_OFF;
        endcase
        if (pwr_off) state_nxt = S_OFF;
    end

    always_ff @(posedge clk) begin
        prev_btn <= bus.power_btn;
        if (rst) begin
            state     <= S_OFF;
            owner     <= M_MANUAL;
            target    <= M_MANUAL;
            drain_cnt <= '0;
            hold_cnt  <= '0;
            armed     <= 1'b0;
            motor_q   <= '0;
        end else begin
            state <= state_nxt;

            // Command only passes while RUN continues, so it is zero on every cycle grant is zero.
            motor_q <= (state == S_RUN && state_nxt == S_RUN) ? sanitise(owner_cmd) : '0;

            if (state == S_OFF) begin
                armed    <= 1'b0;
                hold_cnt <= '0;
            end else begin
                if (!bus.power_btn) armed <= 1'b1;
                if (armed && bus.power_btn) hold_cnt <= hold_cnt + 1'b1;
                else                        hold_cnt <= '0;
            end

            case (state)
                S_OFF: owner <= M_MANUAL;
                S_RUN: begin
                    drain_cnt <= '0;
                    if (req_switch) target <= mode_e'(bus.mode_req);
                end
                S_DRAIN: if (drain_cnt < DRAIN_LAST) drain_cnt <= drain_cnt + 1'b1;
                S_HANDOVER: owner <= target;
                default: ;
            endcase
        end
    end

    assign bus.power_now   = (state != S_OFF);
    assign bus.grant       = grant_c;
    assign bus.motor_cmd   = motor_q;
    assign bus.sched_state = state;
    assign bus.switch_busy = (state == S_DRAIN) || (state == S_HANDOVER);

endmodule

// File: tb/tb_drive_mode_scheduler.sv
// Directed vector bench for drive_mode_scheduler with shortened power-off and drain timers.
module tb_drive_mode_scheduler;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [1:0] req;
        logic [3:0] cm;
        logic [3:0] cs;
        logic [3:0] ca;
        logic [2:0] stp;
        logic [1:0] st;
        logic       pw;
        logic [2:0] gr;
        logic [3:0] mc;
        logic       bz;
    } vec_t;

    localparam logic       L   = 1'b0;
    localparam logic       H   = 1'b1;
    localparam logic [1:0] OFF = 2'b00;
    localparam logic [1:0] RUN = 2'b01;
    localparam logic [1:0] DRN = 2'b10;
    localparam logic [1:0] HND = 2'b11;
    localparam logic [1:0] MM  = 2'b00;
    localparam logic [1:0] MS  = 2'b01;
    localparam logic [1:0] MA  = 2'b10;
    localparam logic [1:0] NO  = 2'b11;
    localparam logic [2:0] G0  = 3'b000;
    localparam logic [2:0] GM  = 3'b001;
    localparam logic [2:0] GS  = 3'b010;
    localparam logic [2:0] GA  = 3'b100;
    localparam logic [3:0] Z4  = 4'b0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n_vecs;
    vec_t vecs[64];

    drive_mode_scheduler_if bus();

    drive_mode_scheduler #(.PWR_OFF_CYC(4), .DRAIN_CYC(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic b, input logic [1:0] q,
                                input logic [3:0] m, input logic [3:0] s, input logic [3:0] a,
                                input logic [2:0] p, input logic [1:0] st, input logic pw,
                                input logic [2:0] gr, input logic [3:0] mc, input logic bz);
        vec_t v;
        v.rst = r;  v.btn = b;  v.req = q;  v.cm = m;  v.cs = s;  v.ca = a;  v.stp = p;
        v.st  = st; v.pw  = pw; v.gr  = gr; v.mc = mc; v.bz = bz;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs[n_vecs] = v;
        n_vecs++;
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [10:0] act;
        logic [10:0] exp;
        rst             = v.rst;
        bus.power_btn   = v.btn;
        bus.mode_req    = v.req;
        bus.cmd_manual  = v.cm;
        bus.cmd_semi    = v.cs;
        bus.cmd_auto    = v.ca;
        bus.stopped_vec = v.stp;
        @(posedge clk);
        #1;
        act = {bus.sched_state, bus.power_now, bus.grant, bus.motor_cmd, bus.switch_busy};
        exp = {v.st, v.pw, v.gr, v.mc, v.bz};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: state=%b pwr=%b grant=%b motor=%b busy=%b, expected state=%b pwr=%b grant=%b motor=%b busy=%b",
                     tag, act[10:9], act[8], act[7:5], act[4:1], act[0],
                     exp[10:9], exp[8], exp[7:5], exp[4:1], exp[0]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        n_vecs = 0;

        // reset, power-on, 10-cycle hold of the power-on press
        add(mk(H, L, NO, Z4, Z4, Z4, 3'b000, OFF, L, G0, Z4, L));
        add(mk(L, L, NO, Z4, Z4, Z4, 3'b000, OFF, L, G0, Z4, L));
        add(mk(L, H, NO, Z4, Z4, Z4, 3'b000, RUN, H, GM, Z4, L));
        for (int i = 0; i < 10; i++)
            add(mk(L, H, NO, Z4, Z4, Z4, 3'b000, RUN, H, GM, Z4, L));
        // sanitise patterns through manual ownership
        add(mk(L, L, NO, 4'b1010, Z4, Z4, 3'b000, RUN, H, GM, 4'b1010, L));
        add(mk(L, L, NO, 4'b1111, Z4, Z4, 3'b000, RUN, H, GM, 4'b0000, L));
        add(mk(L, L, NO, 4'b0110, Z4, Z4, 3'b000, RUN, H, GM, 4'b0110, L));
        add(mk(L, L, NO, 4'b1101, Z4, Z4, 3'b000, RUN, H, GM, 4'b0001, L));
        add(mk(L, L, NO, 4'b1110, 4'b0101, Z4, 3'b000, RUN, H, GM, 4'b0010, L));
        // 3-cycle armed hold then release: stays on
        for (int i = 0; i < 3; i++)
            add(mk(L, H, NO, 4'b1110, 4'b0101, Z4, 3'b000, RUN, H, GM, 4'b0010, L));
        add(mk(L, L, NO, 4'b1110, 4'b0101, Z4, 3'b000, RUN, H, GM, 4'b0010, L));
        add(mk(L, L, MM, 4'b1110, 4'b0101, Z4, 3'b000, RUN, H, GM, 4'b0010, L));
        // switch to auto; mode_req change during drain ignored; wait for stop and drain time
        add(mk(L, L, MA, 4'b1010, 4'b0101, Z4, 3'b000, DRN, H, GM, Z4, H));
        add(mk(L, L, MS, 4'b1010, 4'b0101, Z4, 3'b001, DRN, H, GM, Z4, H));
        add(mk(L, L, MS, 4'b1010, 4'b0101, Z4, 3'b000, DRN, H, GM, Z4, H));
        add(mk(L, L, MS, 4'b1010, 4'b0101, Z4, 3'b000, DRN, H, GM, Z4, H));
        add(mk(L, L, MS, 4'b1010, 4'b0101, Z4, 3'b001, HND, H, G0, Z4, H));
        add(mk(L, L, NO, 4'b1010, 4'b0101, 4'b0101, 3'b000, RUN, H, GA, Z4, L));
        add(mk(L, L, NO, 4'b1111, 4'b0101, 4'b0101, 3'b000, RUN, H, GA, 4'b0101, L));
        add(mk(L, L, NO, 4'b1111, 4'b0101, 4'b1011, 3'b000, RUN, H, GA, 4'b1000, L));
        add(mk(L, L, MA, 4'b1111, 4'b0101, 4'b1011, 3'b000, RUN, H, GA, 4'b1000, L));
        // power-off by 4-cycle hold while draining, overriding the switch
        add(mk(L, L, MM, 4'b1111, 4'b0101, 4'b1011, 3'b000, DRN, H, GA, Z4, H));
        for (int i = 0; i < 3; i++)
            add(mk(L, H, NO, 4'b1111, 4'b0101, 4'b1011, 3'b000, DRN, H, GA, Z4, H));
        add(mk(L, H, NO, 4'b1111, 4'b0101, 4'b1011, 3'b000, OFF, L, G0, Z4, L));
        add(mk(L, H, NO, Z4, Z4, Z4, 3'b000, OFF, L, G0, Z4, L));
        add(mk(L, L, NO, Z4, Z4, Z4, 3'b000, OFF, L, G0, Z4, L));
        // power-off by 4-cycle hold in RUN
        add(mk(L, H, NO, 4'b1000, Z4, Z4, 3'b000, RUN, H, GM, Z4, L));
        add(mk(L, L, NO, 4'b1000, Z4, Z4, 3'b000, RUN, H, GM, 4'b1000, L));
        for (int i = 0; i < 3; i++)
            add(mk(L, H, NO, 4'b1000, Z4, Z4, 3'b000, RUN, H, GM, 4'b1000, L));
        add(mk(L, H, NO, 4'b1000, Z4, Z4, 3'b000, OFF, L, G0, Z4, L));

        for (int i = 0; i < n_vecs; i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // request semi, then auto during drain: semi must win
        apply(mk(L, L, NO, 4'b1010, 4'b0100, Z4, 3'b000, OFF, L, G0, Z4, L), "seq_release");
        apply(mk(L, H, NO, 4'b1010, 4'b0100, Z4, 3'b000, RUN, H, GM, Z4, L), "seq_power_on");
        apply(mk(L, L, MS, 4'b1010, 4'b0100, Z4, 3'b001, DRN, H, GM, Z4, H), "seq_drain_enter");
        apply(mk(L, L, MA, 4'b1010, 4'b0100, Z4, 3'b001, DRN, H, GM, Z4, H), "seq_drain_toggle1");
        apply(mk(L, L, MA, 4'b1010, 4'b0100, Z4, 3'b001, DRN, H, GM, Z4, H), "seq_drain_toggle2");
        apply(mk(L, L, MA, 4'b1010, 4'b0100, Z4, 3'b001, HND, H, G0, Z4, H), "seq_handover");
        apply(mk(L, L, NO, 4'b1010, 4'b0100, Z4, 3'b000, RUN, H, GS, Z4, L), "seq_owner_semi");
        apply(mk(L, L, NO, 4'b1010, 4'b0100, Z4, 3'b000, RUN, H, GS, 4'b0100, L), "seq_semi_cmd");

        // reset asserted while in HANDOVER
        apply(mk(L, L, MA, 4'b1010, 4'b0100, Z4, 3'b010, DRN, H, GS, Z4, H), "seq_drain2_enter");
        apply(mk(L, L, MA, 4'b1010, 4'b0100, Z4, 3'b010, DRN, H, GS, Z4, H), "seq_drain2_a");
        apply(mk(L, L, MA, 4'b1010, 4'b0100, Z4, 3'b010, DRN, H, GS, Z4, H), "seq_drain2_b");
        apply(mk(L, L, MA, 4'b1010, 4'b0100, Z4, 3'b010, HND, H, G0, Z4, H), "seq_handover2");
        apply(mk(H, L, NO, 4'b1010, 4'b0100, Z4, 3'b000, OFF, L, G0, Z4, L), "seq_reset_in_handover");
        apply(mk(L, L, NO, 4'b1010, 4'b0100, Z4, 3'b000, OFF, L, G0, Z4, L), "seq_after_reset");
        apply(mk(L, H, NO, 4'b1010, 4'b0100, Z4, 3'b000, RUN, H, GM, Z4, L), "seq_repower_manual");
        apply(mk(L, H, NO, 4'b1010, 4'b0100, Z4, 3'b000, RUN, H, GM, 4'b1010, L), "seq_repower_cmd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
